// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with an internal dual-port memory.
// It provides occupancy flags, sticky error flags, and show-ahead or registered read data.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = RAM_DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter bit OUTPUT_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH &&
        AF_THRESH <= RAM_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_ctrl: threshold parameters out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign count        = count_q;

  // Accepts are gated by clear so a flush cycle never touches memory.
  assign wr_acc = wr_en & ~full & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en & full);
    udf_d    = udf_q | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  if (OUTPUT_REG) begin : g_reg_out
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_show_ahead
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a show-ahead and a registered instance share one stimulus.
// A queue-based reference model supplies every expected value.
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic full0, af0, ovf0, empty0, ae0, udf0, rv0;
  logic [DW-1:0] rd0;
  logic [AW:0] cnt0;
  logic full1, af1, ovf1, empty1, ae1, udf1, rv1;
  logic [DW-1:0] rd1;
  logic [AW:0] cnt1;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  bit m_ovf, m_udf, m_rv;
  byte unsigned m_rd;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
    .AE_THRESH(AE), .OUTPUT_REG(1'b0)
  ) u_sa (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(full0), .almost_full(af0), .overflow(ovf0),
    .rd_en(rd_en), .rd_data(rd0), .rd_valid(rv0),
    .empty(empty0), .almost_empty(ae0), .underflow(udf0),
    .count(cnt0)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF),
    .AE_THRESH(AE), .OUTPUT_REG(1'b1)
  ) u_rg (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(full1), .almost_full(af1), .overflow(ovf1),
    .rd_en(rd_en), .rd_data(rd1), .rd_valid(rv1),
    .empty(empty1), .almost_empty(ae1), .underflow(udf1),
    .count(cnt1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rv  = 0;
    m_rd  = 0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit c,
                            input byte unsigned d);
    bit was_full, was_empty;
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_rv  = 0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (w && was_full) m_ovf = 1;
    if (r && was_empty) m_udf = 1;
    m_rv = 0;
    if (r && !was_empty) begin
      m_rd = q.pop_front();
      m_rv = 1;
    end
    if (w && !was_full) q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count0"}, int'(cnt0), n);
    chk({tag, ".count1"}, int'(cnt1), n);
    chk({tag, ".empty"}, int'({empty0, empty1}), (n == 0) ? 3 : 0);
    chk({tag, ".full"}, int'({full0, full1}), (n == DEPTH) ? 3 : 0);
    chk({tag, ".aempty"}, int'({ae0, ae1}), (n <= AE) ? 3 : 0);
    chk({tag, ".afull"}, int'({af0, af1}), (n >= AF) ? 3 : 0);
    chk({tag, ".ovf"}, int'({ovf0, ovf1}), m_ovf ? 3 : 0);
    chk({tag, ".udf"}, int'({udf0, udf1}), m_udf ? 3 : 0);
    chk({tag, ".valid0"}, int'(rv0), (n != 0) ? 1 : 0);
    if (n != 0) chk({tag, ".head0"}, int'(rd0), int'(q[0]));
    chk({tag, ".valid1"}, int'(rv1), int'(m_rv));
    chk({tag, ".data1"}, int'(rd1), int'(m_rd));
  endtask

  task automatic cycle(input string tag, input bit w, input bit r,
                       input bit c, input byte unsigned d);
    wr_en   = w;
    rd_en   = r;
    clear   = c;
    wr_data = d;
    @(posedge clk);
    model_step(w, r, c, d);
    @(negedge clk);
    wr_en = 0;
    rd_en = 0;
    clear = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check_all("reset_rel");

    // fill and drain in show-ahead order
    for (int i = 0; i < 8; i++)
      cycle("fill", 1, 0, 0, 8'(8'h10 + i));
    cycle("ovf_full", 1, 0, 0, 8'hAA);
    for (int i = 0; i < 8; i++)
      cycle("drain", 0, 1, 0, 8'h00);
    cycle("udf_empty", 0, 1, 0, 8'h00);
    cycle("clear_flags", 0, 0, 1, 8'h00);

    // simultaneous access at the boundaries
    for (int i = 0; i < 8; i++)
      cycle("fill2", 1, 0, 0, 8'(8'h20 + i));
    cycle("both_full", 1, 1, 0, 8'hBB);
    while (q.size() != 0) cycle("drain2", 0, 1, 0, 8'h00);
    cycle("both_empty", 1, 1, 0, 8'h5C);
    cycle("read_wt", 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++)
      cycle("fill4", 1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++)
      cycle("both_wrap", 1, 1, 0, 8'(8'h60 + i));
    while (q.size() != 0) cycle("drain3", 0, 1, 0, 8'h00);

    // registered-read latency and hold
    cycle("reg_w1", 1, 0, 0, 8'h01);
    cycle("reg_w2", 1, 0, 0, 8'h02);
    cycle("reg_rd", 0, 1, 0, 8'h00);
    cycle("reg_hold", 0, 0, 0, 8'h00);
    cycle("reg_rd2", 0, 1, 0, 8'h00);

    // clear wins over same-cycle accesses
    for (int i = 0; i < 3; i++)
      cycle("pre_clr", 1, 0, 0, 8'(8'h70 + i));
    cycle("clr_prec", 1, 1, 1, 8'hEE);
    cycle("post_clr_w", 1, 0, 0, 8'h99);
    cycle("post_clr_r", 0, 1, 0, 8'h00);

    // asynchronous reset mid-operation with count 5
    for (int i = 0; i < 5; i++)
      cycle("pre_rst", 1, 0, 0, 8'(8'h80 + i));
    #2 rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 0;
    check_all("rst_rel2");

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      wp = (i / 100) % 2 == 0 ? 70 : 35;
      rp = 105 - wp;
      cycle("rand",
            $urandom_range(99) < wp,
            $urandom_range(99) < rp,
            $urandom_range(63) == 0,
            8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
